// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with first-word-fall-through
// read data, almost-full/almost-empty thresholds and overflow/underflow flags.
// Optional feature macro: FIFO_STICKY_ERR_EN. When it is defined, the error
// flags stay set until reset. When it is undefined, each error flag is a
// one-cycle pulse.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  isEmpty,
  output logic                  isFull,
  output logic                  isAlmostEmpty,
  output logic                  isAlmostFull,
  output logic                  isBusy,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic empty_c, full_c;
  logic wr_acc_c, rd_acc_c;
  logic ovf_ev_c, udf_ev_c;

  // Status decoded straight from the occupancy register.
  assign empty_c = (count_q == CW'(0));
  assign full_c  = (count_q == CW'(DEPTH));

  // Handshake: a full FIFO still accepts a write if a pop frees a slot this cycle.
  assign wr_acc_c = we & (~full_c | re);
  assign rd_acc_c = re & ~empty_c;
  assign ovf_ev_c = we & full_c & ~re;
  assign udf_ev_c = re & empty_c;

  // Next-state for pointers, occupancy and error flags.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (wr_acc_c) begin
      wp_d = wp_q + ADDR_WIDTH'(1);
    end
    if (rd_acc_c) begin
      rp_d = rp_q + ADDR_WIDTH'(1);
    end

    if (wr_acc_c && !rd_acc_c) begin
      count_d = count_q + CW'(1);
    end else if (rd_acc_c && !wr_acc_c) begin
      count_d = count_q - CW'(1);
    end

`ifdef FIFO_STICKY_ERR_EN
    ovf_d = ovf_q | ovf_ev_c;
    udf_d = udf_q | udf_ev_c;
`else
    ovf_d = ovf_ev_c;
    udf_d = udf_ev_c;
`endif
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array, intentionally not reset; contents are gated by the pointers.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc_c) begin
      mem_q[wp_q] <= dataIn;
    end
  end

  assign dataOut       = mem_q[rp_q];
  assign count         = count_q;
  assign isEmpty       = empty_c;
  assign isFull        = full_c;
  assign isAlmostEmpty = (count_q <= CW'(AEMPTY_THRESH));
  assign isAlmostFull  = (count_q >= CW'(AFULL_THRESH));
  assign isBusy        = re | we;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at depth 4 (AFULL_THRESH=3, AEMPTY_THRESH=1).
// Error-flag expectations follow FIFO_STICKY_ERR_EN when it is defined.
module tb_sync_fifo_param;

  logic       clk;
  logic       reset;
  logic [7:0] dataIn;
  logic       we;
  logic       re;
  logic [7:0] dataOut;
  logic [2:0] count;
  logic       isEmpty, isFull, isAlmostEmpty, isAlmostFull, isBusy;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  sync_fifo_param #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (2),
    .AFULL_THRESH (3),
    .AEMPTY_THRESH(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dataIn       (dataIn),
    .we           (we),
    .re           (re),
    .dataOut      (dataOut),
    .count        (count),
    .isEmpty      (isEmpty),
    .isFull       (isFull),
    .isAlmostEmpty(isAlmostEmpty),
    .isAlmostFull (isAlmostFull),
    .isBusy       (isBusy),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    we     = w;
    re     = r;
    dataIn = d;
  endtask

  initial begin
    logic [7:0] exp_d;

    // Reset held two cycles while both requests are active.
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'hAA);
    tick();
    tick();
    chk("rst_count",  32'(count), 32'd0);
    chk("rst_empty",  32'(isEmpty), 32'd1);
    chk("rst_aempty", 32'(isAlmostEmpty), 32'd1);
    chk("rst_full",   32'(isFull), 32'd0);
    chk("rst_afull",  32'(isAlmostFull), 32'd0);
    chk("rst_ovf",    32'(overflow), 32'd0);
    chk("rst_udf",    32'(underflow), 32'd0);
    chk("busy_hi",    32'(isBusy), 32'd1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    #1;
    chk("busy_lo", 32'(isBusy), 32'd0);
    tick();
    chk("idle_count", 32'(count), 32'd0);

    // Fill 0x11..0x44.
    drive(1'b1, 1'b0, 8'h11); tick();
    chk("f1_count",  32'(count), 32'd1);
    chk("f1_dout",   32'(dataOut), 32'h11);
    chk("f1_empty",  32'(isEmpty), 32'd0);
    chk("f1_aempty", 32'(isAlmostEmpty), 32'd1);
    drive(1'b1, 1'b0, 8'h22); tick();
    chk("f2_count",  32'(count), 32'd2);
    chk("f2_aempty", 32'(isAlmostEmpty), 32'd0);
    chk("f2_afull",  32'(isAlmostFull), 32'd0);
    drive(1'b1, 1'b0, 8'h33); tick();
    chk("f3_count",  32'(count), 32'd3);
    chk("f3_afull",  32'(isAlmostFull), 32'd1);
    chk("f3_full",   32'(isFull), 32'd0);
    drive(1'b1, 1'b0, 8'h44); tick();
    chk("f4_count",  32'(count), 32'd4);
    chk("f4_full",   32'(isFull), 32'd1);
    chk("f4_dout",   32'(dataOut), 32'h11);

    // Drain four in order.
    drive(1'b0, 1'b1, 8'h00);
    chk("d1_dout", 32'(dataOut), 32'h11); tick();
    chk("d2_dout", 32'(dataOut), 32'h22); tick();
    chk("d3_dout", 32'(dataOut), 32'h33); tick();
    chk("d4_dout", 32'(dataOut), 32'h44); tick();
    chk("d_count", 32'(count), 32'd0);
    chk("d_empty", 32'(isEmpty), 32'd1);
    chk("d_full",  32'(isFull), 32'd0);

    // Refill, then write while full.
    drive(1'b1, 1'b0, 8'h11); tick();
    drive(1'b1, 1'b0, 8'h22); tick();
    drive(1'b1, 1'b0, 8'h33); tick();
    drive(1'b1, 1'b0, 8'h44); tick();
    drive(1'b1, 1'b0, 8'h55); tick();
    chk("ov_count", 32'(count), 32'd4);
    chk("ov_flag",  32'(overflow), 32'd1);
    chk("ov_dout",  32'(dataOut), 32'h11);
    drive(1'b0, 1'b0, 8'h00); tick();
    chk("ov_after", 32'(overflow), 32'(STICKY));
    chk("ov_count2", 32'(count), 32'd4);

    // Simultaneous read/write while full.
    drive(1'b1, 1'b1, 8'h66); tick();
    chk("sf_dout",  32'(dataOut), 32'h22);
    chk("sf_count", 32'(count), 32'd4);
    chk("sf_ovf",   32'(overflow), 32'(STICKY));
    drive(1'b0, 1'b1, 8'h00);
    tick(); chk("sf_p2", 32'(dataOut), 32'h33);
    tick(); chk("sf_p3", 32'(dataOut), 32'h44);
    tick(); chk("sf_p4", 32'(dataOut), 32'h66);
    chk("sf_cnt1", 32'(count), 32'd1);
    tick();
    chk("sf_empty", 32'(isEmpty), 32'd1);
    chk("sf_udf",   32'(underflow), 32'd0);

    // Simultaneous read/write while empty.
    drive(1'b1, 1'b1, 8'h77); tick();
    chk("se_count", 32'(count), 32'd1);
    chk("se_dout",  32'(dataOut), 32'h77);
    chk("se_udf",   32'(underflow), 32'd1);
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("se_pop_count", 32'(count), 32'd0);
    chk("se_pop_udf",   32'(underflow), 32'(STICKY));

    // Plain read while empty.
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("ud_count", 32'(count), 32'd0);
    chk("ud_flag",  32'(underflow), 32'd1);
    drive(1'b0, 1'b0, 8'h00); tick();
    chk("ud_after", 32'(underflow), 32'(STICKY));

    // Wrap-around: prime with two entries, then ten cycles of read+write.
    drive(1'b1, 1'b0, 8'hA0); tick();
    drive(1'b1, 1'b0, 8'hA1); tick();
    chk("wr_prime", 32'(count), 32'd2);
    chk("wr_head",  32'(dataOut), 32'hA0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 8'(i));
      tick();
      exp_d = (i == 0) ? 8'hA1 : 8'(i - 1);
      chk($sformatf("wr_dout%0d", i), 32'(dataOut), 32'(exp_d));
      chk($sformatf("wr_cnt%0d", i),  32'(count), 32'd2);
    end
    drive(1'b0, 1'b1, 8'h00); tick();
    chk("wr_tail", 32'(dataOut), 32'h09);
    chk("wr_tail_cnt", 32'(count), 32'd1);

    // Mid-operation reset clears everything, including sticky flags.
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'hEE); tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    chk("rr_count", 32'(count), 32'd0);
    chk("rr_empty", 32'(isEmpty), 32'd1);
    chk("rr_ovf",   32'(overflow), 32'd0);
    chk("rr_udf",   32'(underflow), 32'd0);
    tick();
    chk("rr_idle",  32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the successor of the team's fixed 8-bit byte FIFO. It generalises data width and depth and accepts a read and a write in the same cycle. It adds almost-full/almost-empty thresholds and overflow/underflow error reporting. It sits between byte/word producers (UART RX, keypad scanner) and consumers (display, TX) in the single-clock domain.

## Interface
- DATA_WIDTH, 8: bits per entry.
- ADDR_WIDTH, 10: pointer width; depth = 2^ADDR_WIDTH entries.
- AFULL_THRESH, 2^ADDR_WIDTH-4: isAlmostFull asserted when count ≥ this value.
- AEMPTY_THRESH, 4: isAlmostEmpty asserted when count ≤ this value.

- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- dataIn  in  DATA_WIDTH  write data.
- we  in  1  write request.
- re  in  1  read request (pop).
- dataOut  out  DATA_WIDTH  head entry (first-word-fall-through).
- count  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- isEmpty, isFull  out  1  count==0 / count==2^ADDR_WIDTH.
- isAlmostEmpty, isAlmostFull  out  1  threshold flags.
- isBusy  out  1  re | we (combinational).
- overflow, underflow  out  1  error flags (see Configuration).

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH array. Not reset. Write pointer wp and read pointer rp are ADDR_WIDTH bits wide and wrap modulo depth naturally.
- dataOut = mem[rp], combinational. Valid whenever !isEmpty. Value is don't-care when empty.
- Accepted write (wa): we & (!isFull | re).
  - Store dataIn at wp; wp+1.
- Accepted read (ra): re & !isEmpty.
  - rp+1.
- count update:
  - +1 on wa & !ra.
  - −1 on ra & !wa.
  - Unchanged on both or neither.
- Simultaneous re & we:
  - Not empty: both accepted, including when full; count unchanged.
  - Empty: write accepted, read rejected; count becomes 1; underflow event.
- Write when full without re: data dropped, no state change, overflow event.
- Read when empty without we: no state change, underflow event.
- Flags are combinational from the count register: isEmpty, isFull, isAlmostEmpty, isAlmostFull.
- Reset values:
  - count=0, wp=rp=0.
  - isEmpty=1, isAlmostEmpty=1 (AEMPTY_THRESH ≥ 0).
  - isFull=0, isAlmostFull=0, overflow=0, underflow=0.
- Reset has priority over re/we in the same cycle. Reset mid-operation discards all contents.
- Legal parameters: 0 ≤ AEMPTY_THRESH < AFULL_THRESH ≤ 2^ADDR_WIDTH, ADDR_WIDTH ≥ 1.

## Timing
- Write to readable: data written at edge N is on dataOut from edge N (if it was empty) and is poppable at edge N+1. One-cycle latency, no bubbles.
- Read: the pop at edge N presents the next entry on dataOut immediately after edge N.
- count and all status flags reflect the accepted operations immediately after the edge that performs them.
- Throughput: one write and one read per cycle sustained.
- isBusy and dataOut have no register stage.

## Configuration
- FIFO_STICKY_ERR_EN defined:
  - overflow/underflow set on their event and stay 1 until reset.
- FIFO_STICKY_ERR_EN undefined:
  - overflow/underflow are one-cycle pulses, registered. The flag is high for exactly the cycle after the edge at which the rejected request was sampled.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert reset 2 cycles with we=re=1 → count=0, isEmpty=1, isAlmostEmpty=1, isFull=0, overflow=underflow=0.
- Fill/drain, ADDR_WIDTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1:
  - Write 0x11,0x22,0x33,0x44 → count steps 1..4; isAlmostFull from count 3; isFull at 4.
  - Read 4 → dataOut 0x11,0x22,0x33,0x44 in order; isEmpty at end.
- Overflow, depth 4 full:
  - we=1, re=0 with 0x55 → count stays 4, overflow high, contents unchanged.
  - Pulse build: 1 cycle only. Sticky build: held until reset.
- Simultaneous when full: re=we=1 with 0x66 → dataOut advances 0x11→0x22, count stays 4; 0x66 emerges as 4th pop later.
- Simultaneous when empty: re=we=1 with 0x77 → count=1, dataOut=0x77, underflow asserted.
- Wrap-around: 10 cycles of continuous re=we=1 at count=2, data 0x00..0x09 → output sequence preserves order across pointer wrap; count remains 2 throughout.
